// File: rtl/pwm_ctrl_pkg.sv
// Shared types for the pulse-width monitor: channel FSM states,
// the width record carried from channel slot to event output.
package pwm_ctrl_pkg;

  localparam int MAX_CH_W = 8;
  localparam int MAX_W = 32;

  typedef enum logic {
    IDLE,
    HIGH
  } ch_state_e;

  // Sized for the widest supported build; the top narrows on output.
  typedef struct packed {
    logic [MAX_CH_W-1:0] ch;
    logic [MAX_W-1:0]    width;
    logic                sat;
  } rec_t;

  function automatic int ch_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pulse_width_monitor_ctrl_channel.sv
// One monitored line: edge detect, high-time counter, threshold
// compare, live detection level and record-post strobe.
module pulse_width_channel
  import pwm_ctrl_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sig,
  input  logic             enable,
  input  logic [WIDTH-1:0] threshold,
  output logic             detected,
  output logic             post,
  output logic [WIDTH-1:0] rec_width,
  output logic             rec_sat
);

  ch_state_e        state;
  ch_state_e        state_n;
  logic             prev;
  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] cnt_n;
  logic             sat_q;
  logic             sat_n;
  logic             det_n;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      prev     <= 1'b0;
      cnt      <= '0;
      sat_q    <= 1'b0;
      detected <= 1'b0;
    end else begin
      state    <= state_n;
      prev     <= sig;
      cnt      <= cnt_n;
      sat_q    <= sat_n;
      detected <= det_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    sat_n   = sat_q;
    post    = 1'b0;
    unique case (state)
      IDLE: begin
        // Arm only on a true rising edge seen while enabled.
        if (sig && !prev && enable) begin
          state_n = HIGH;
          cnt_n   = WIDTH'(1);
          sat_n   = 1'b0;
        end
      end
      HIGH: begin
        if (!enable) begin
          state_n = IDLE;
          cnt_n   = '0;
          sat_n   = 1'b0;
        end else if (sig) begin
          if (&cnt) begin
            sat_n = 1'b1;
          end else begin
            cnt_n = cnt + WIDTH'(1);
          end
        end else begin
          post    = (cnt >= threshold);
          state_n = IDLE;
          cnt_n   = '0;
          sat_n   = 1'b0;
        end
      end
      default: state_n = IDLE;
    endcase
    det_n = (state_n == HIGH) && (cnt_n >= threshold);
  end

  assign rec_width = cnt;
  assign rec_sat   = sat_q;

endmodule

// File: rtl/pulse_width_monitor_ctrl.sv
// Multi-channel pulse-width monitor: per-channel thresholds,
// one pending record per channel, round-robin event output.
module pulse_width_monitor_ctrl
  import pwm_ctrl_pkg::*;
#(
  parameter int              NUM_CH      = 4,
  parameter int              WIDTH       = 8,
  parameter logic [WIDTH-1:0] DEFAULT_THR = WIDTH'(8'hFF),
  localparam int             CH_W        = ch_width(NUM_CH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] signal_in,
  input  logic [NUM_CH-1:0] ch_enable,
  input  logic              cfg_we,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [WIDTH-1:0]  cfg_threshold,
  output logic [NUM_CH-1:0] pulse_detected,
  output logic              evt_valid,
  input  logic              evt_ready,
  output logic [CH_W-1:0]   evt_ch,
  output logic [WIDTH-1:0]  evt_width,
  output logic              evt_sat,
  output logic [WIDTH-1:0]  drop_count
);

  logic [WIDTH-1:0]  thr [NUM_CH];
  logic [NUM_CH-1:0] post;
  logic [WIDTH-1:0]  pw [NUM_CH];
  logic [NUM_CH-1:0] ps;

  logic [NUM_CH-1:0] pend;
  logic [NUM_CH-1:0] pend_n;
  rec_t              slot [NUM_CH];
  rec_t              slot_n [NUM_CH];
  rec_t              out_q;

  logic [CH_W-1:0]   ptr;
  logic [CH_W-1:0]   ptr_n;
  logic [CH_W-1:0]   grant;
  logic              found;
  logic              load;
  logic [NUM_CH-1:0] clr;
  logic [WIDTH-1:0]  drop_n;
  int                idx;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    pulse_width_channel #(
      .WIDTH(WIDTH)
    ) u_ch (
      .clk      (clk),
      .rst      (rst),
      .sig      (signal_in[g]),
      .enable   (ch_enable[g]),
      .threshold(thr[g]),
      .detected (pulse_detected[g]),
      .post     (post[g]),
      .rec_width(pw[g]),
      .rec_sat  (ps[g])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) begin
        thr[i] <= DEFAULT_THR;
      end
    end else if (cfg_we && (int'(cfg_ch) < NUM_CH)) begin
      thr[cfg_ch] <= cfg_threshold;
    end
  end

  assign load = !evt_valid || evt_ready;

  // First pending channel at or after the pointer, wrapping.
  always_comb begin
    found = 1'b0;
    grant = '0;
    idx   = 0;
    for (int k = 0; k < NUM_CH; k++) begin
      idx = (int'(ptr) + k) % NUM_CH;
      if (!found && pend[idx]) begin
        found = 1'b1;
        grant = CH_W'(idx);
      end
    end
  end

  always_comb begin
    ptr_n = grant + CH_W'(1);
    if (int'(grant) == NUM_CH - 1) begin
      ptr_n = '0;
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      clr[i] = load && found && (int'(grant) == i);
    end
  end

  // A slot freed by this cycle's grant may be refilled at once.
  always_comb begin
    pend_n = pend;
    drop_n = drop_count;
    for (int i = 0; i < NUM_CH; i++) begin
      slot_n[i] = slot[i];
    end
    for (int i = 0; i < NUM_CH; i++) begin
      if (post[i]) begin
        if (pend[i] && !clr[i]) begin
          if (!(&drop_n)) begin
            drop_n = drop_n + WIDTH'(1);
          end
        end else begin
          pend_n[i] = 1'b1;
          slot_n[i] = '{
            ch:    MAX_CH_W'(i),
            width: MAX_W'(pw[i]),
            sat:   ps[i]
          };
        end
      end else if (clr[i]) begin
        pend_n[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend       <= '0;
      out_q      <= '0;
      evt_valid  <= 1'b0;
      ptr        <= '0;
      drop_count <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        slot[i] <= '0;
      end
    end else begin
      pend       <= pend_n;
      drop_count <= drop_n;
      for (int i = 0; i < NUM_CH; i++) begin
        slot[i] <= slot_n[i];
      end
      if (load) begin
        evt_valid <= found;
        if (found) begin
          out_q <= slot[grant];
          ptr   <= ptr_n;
        end
      end
    end
  end

  assign evt_ch    = out_q.ch[CH_W-1:0];
  assign evt_width = out_q.width[WIDTH-1:0];
  assign evt_sat   = out_q.sat;

  logic unused_rec;
  assign unused_rec = ^{out_q.ch[MAX_CH_W-1:CH_W],
                        out_q.width[MAX_W-1:WIDTH]};

endmodule

// File: doc/pulse_width_monitor_ctrl.md
Name: pulse_width_monitor_ctrl

Overview:
Multi-channel pulse-width monitor and event scheduler. Each channel measures the high time of its input in clk cycles against a per-channel programmable threshold. Each channel drives a live detection level. Each qualifying pulse posts a width record, and a round-robin arbiter funnels the records onto one valid/ready event stream. The block sits between raw synchronous status lines and a single event consumer such as a CSR FIFO or interrupt logic.

Parameters:
NUM_CH, 4, number of monitored channels (>=2)
WIDTH, 8, counter/threshold/width field width
DEFAULT_THR, 8'hFF, per-channel threshold after reset (WIDTH bits)

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
signal_in  in  NUM_CH  monitored lines; already synchronous to clk
ch_enable  in  NUM_CH  per-channel enable
cfg_we  in  1  threshold write strobe
cfg_ch  in  CH_W  channel to write; CH_W = max(1, clog2(NUM_CH))
cfg_threshold  in  WIDTH  threshold value
pulse_detected  out  NUM_CH  per-channel level: current pulse has reached threshold
evt_valid  out  1  event record valid
evt_ready  in  1  consumer accepts record
evt_ch  out  CH_W  channel of record
evt_width  out  WIDTH  pulse width in cycles (saturated)
evt_sat  out  1  width counter saturated during the pulse
drop_count  out  WIDTH  records lost because the channel slot was full; saturating

Behaviour:
- Reset values: all outputs 0; thresholds = DEFAULT_THR; all counters, pending slots and channel FSMs cleared; RR pointer = 0.
- Width count = number of rising clk edges at which signal_in is sampled high.
- Per-channel FSM: IDLE, HIGH. prev register tracks signal_in every cycle regardless of enable.
  - IDLE -> HIGH on rising edge (in=1, prev=0) with ch_enable=1. Count loads 1.
  - HIGH with in=1: count increments, saturates at all-ones, sets sticky sat.
  - HIGH with in=0 (falling edge): if count >= threshold, post record {ch, count, sat}. Then -> IDLE and clear count/sat.
  - ch_enable=0 in HIGH: abort to IDLE, no record, pulse_detected cleared. Enabling while the line is already high does not arm the channel; it waits for the next rising edge.
- pulse_detected[i] is registered: it is 1 in the cycle after the sampling edge where state becomes or stays HIGH and count_next >= threshold[i]. It clears the cycle after the falling edge. Threshold 0 or 1 gives detection one cycle after the rising edge.
- Threshold writes: cfg_we updates threshold[cfg_ch] at the clock edge. A cfg_ch >= NUM_CH is ignored. A write mid-pulse takes effect from the next comparison.
- Pending slot: one record per channel. If the slot is full when a new record posts, the new record is dropped (the older one is kept) and drop_count increments, saturating. Multiple drops in the same cycle add their total count.
- Arbiter and output register:
  - The output register loads when evt_valid=0, or when evt_valid=1 and evt_ready=1.
  - The grant goes to the first pending channel at or after the RR pointer, wrapping. The pointer then becomes grant+1 mod NUM_CH.
  - The granted slot clears. A same-cycle post to that channel refills the slot without a drop.
  - Throughput: one record per cycle while evt_ready=1. Latency from falling-edge sampling to evt_valid is 2 cycles when idle (slot, then output register).
  - If nothing is pending on a load cycle, evt_valid drops to 0.
- Handshake: while evt_valid=1 and evt_ready=0, evt_ch, evt_width and evt_sat are held stable.
- Asynchronous reset mid-pulse or mid-handshake discards all state and records.

Decomposition:
- Package pwm_ctrl_pkg holds CH_W computation, the FSM state enum {IDLE, HIGH}, and the record typedef {ch, width, sat}.
- Sub-module pulse_width_channel, instantiated NUM_CH times. It contains the FSM, counter, sat flag, compare, pulse_detected and the record-post strobe.
- The top level holds the threshold regs, pending slots, RR arbiter, output register and drop counter.

Test Plan:
- Threshold: thr[0]=3. 5-cycle pulse on ch0 -> pulse_detected[0] rises 1 cycle after the 3rd high sample and falls after the edge; record {0,5,0} appears 2 cycles after the falling edge.
- Below threshold: thr[1]=10, 4-cycle pulse -> no pulse_detected, no record, drop_count=0.
- Saturation: WIDTH=8, thr=200, 300-cycle pulse -> record width=255, sat=1.
- Round-robin: ch0..ch3 all post in the same cycle with evt_ready=1 -> records in order 0,1,2,3 on consecutive cycles. A repeat with the pointer at 2 gives 2,3,0,1.
- Backpressure and drop: evt_ready=0 while ch2 posts three records -> the first is held stable on the output, the second sits in the slot, the third is dropped, drop_count=1. After release, records 1 then 2 are delivered.
- Enable/reset: ch_enable[0] deasserted mid-pulse -> no record; re-enabled while high -> no arming until the next rising edge. rst asserted mid-handshake -> all outputs 0, thresholds revert to DEFAULT_THR.
